// File: rtl/uart_bridge_wb.sv
`default_nettype none
// ============================================================================
// Module      : uart_bridge_wb
// Description : Wishbone slave front-end for the UART register file, 8-bit
//               bus mode. Registers the Wishbone request. For each accepted
//               access it produces one single-cycle register write or read
//               strobe and then a one-cycle ack. Read data is returned to the
//               bus through an output register.
// Ports       : clk         - system clock, rising edge
//               wb_rst_i    - synchronous active-high reset
//               wb_dat_i    - bus write data
//               wb_dat_o    - bus read data (registered)
//               wb_dat8_i   - registered write data to the register file
//               wb_dat8_o   - register file read data at wb_adr_int
//               wb_dat32_o  - debug read data (ignored in 8-bit mode)
//               wb_sel_i    - byte selects (ignored in 8-bit mode)
//               wb_we_i     - bus write enable
//               wb_stb_i    - bus strobe
//               wb_cyc_i    - bus cycle
//               wb_ack_o    - one-cycle acknowledge
//               wb_adr_i    - bus register address
//               wb_adr_int  - registered address to the register file
//               we_o        - register write strobe
//               re_o        - register read strobe
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bridge_wb (
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic [7:0]  wb_dat_i,
  output logic [7:0]  wb_dat_o,
  output logic [7:0]  wb_dat8_i,
  input  logic [7:0]  wb_dat8_o,
  input  logic [31:0] wb_dat32_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic [2:0]  wb_adr_i,
  output logic [2:0]  wb_adr_int,
  output logic        we_o,
  output logic        re_o
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_wre;
  logic       w_wre_nxt;
  logic       w_ack_nxt;
  logic       w_req;

  logic       r_wb_we_is;
  logic       r_wb_stb_is;
  logic       r_wb_cyc_is;
  logic [2:0] r_wb_adr_is;
  logic [7:0] r_wb_dat_is;

  // The 32-bit debug data and byte selects have no role in 8-bit mode.
  logic       w_unused_inputs;
  assign w_unused_inputs = ^{wb_dat32_o, wb_sel_i};

  // Request input registers, sampled every clock.
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      r_wb_we_is  <= 1'b0;
      r_wb_stb_is <= 1'b0;
      r_wb_cyc_is <= 1'b0;
      r_wb_adr_is <= 3'd0;
      r_wb_dat_is <= 8'd0;
    end else begin
      r_wb_we_is  <= wb_we_i;
      r_wb_stb_is <= wb_stb_i;
      r_wb_cyc_is <= wb_cyc_i;
      r_wb_adr_is <= wb_adr_i;
      r_wb_dat_is <= wb_dat_i;
    end
  end

  // Read data register: during the ack cycle it holds the value the register
  // file presented for the strobed address one cycle earlier.
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      wb_dat_o <= 8'd0;
    end else begin
      wb_dat_o <= wb_dat8_o;
    end
  end

  assign wb_adr_int = r_wb_adr_is;
  assign wb_dat8_i  = r_wb_dat_is;

  assign w_req = r_wb_stb_is & r_wb_cyc_is;

  // wre is only high while idle in S0, so a held request yields exactly one
  // strobe per pass through S0..S3.
  assign we_o =  r_wb_we_is & w_req & r_wre;
  assign re_o = ~r_wb_we_is & w_req & r_wre;

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      r_state  <= S0;
      r_wre    <= 1'b1;
      wb_ack_o <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wre    <= w_wre_nxt;
      wb_ack_o <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wre_nxt   = 1'b0;
    w_ack_nxt   = 1'b0;
    case (r_state)
      S0: begin
        if (w_req) begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = S1;
        end else begin
          w_wre_nxt   = 1'b1;
        end
      end
      S1: w_state_nxt = S2;
      S2: w_state_nxt = S3;
      S3: begin
        // Re-arm on the way back to S0 so a request still held is strobed
        // in the first S0 cycle, giving the 4-cycle transaction spacing.
        w_state_nxt = S0;
        w_wre_nxt   = 1'b1;
      end
      default: w_state_nxt = S0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_bridge_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_bridge_wb
// Description : Self-checking bench for uart_bridge_wb. A transaction-level
//               reference model predicts, for every driven cycle, which
//               strobe and ack the bridge must produce and when; predictions
//               are queued and a monitor compares them with the DUT outputs.
//               A small register file stub answers reads and absorbs writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bridge_wb;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [7:0]  wb_dat_i = 8'd0;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat8_i;
  logic [7:0]  wb_dat8_o;
  logic [31:0] wb_dat32_o = 32'd0;
  logic [3:0]  wb_sel_i = 4'd0;
  logic        wb_we_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic [2:0]  wb_adr_i = 3'd0;
  logic [2:0]  wb_adr_int;
  logic        we_o;
  logic        re_o;

  uart_bridge_wb dut (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_dat8_i  (wb_dat8_i),
    .wb_dat8_o  (wb_dat8_o),
    .wb_dat32_o (wb_dat32_o),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_ack_o   (wb_ack_o),
    .wb_adr_i   (wb_adr_i),
    .wb_adr_int (wb_adr_int),
    .we_o       (we_o),
    .re_o       (re_o)
  );

  always #5 clk = ~clk;

  // Cycle k is the interval between rising edge k and rising edge k+1.
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Register file stub.
  logic [7:0] stub_mem [8];
  assign wb_dat8_o = stub_mem[wb_adr_int];
  always @(posedge clk) if (we_o === 1'b1) stub_mem[wb_adr_int] <= wb_dat8_i;

  typedef struct {
    int         cyc;
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
  } strobe_t;

  typedef struct {
    int         cyc;
    logic       we;
    logic [7:0] rdata;
  } ack_t;

  strobe_t sq[$];
  ack_t    aq[$];
  strobe_t es;
  ack_t    ea;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state: register contents and the cycle of the last
  // accepted access (the bridge is idle again 4 cycles after a strobe).
  logic [7:0] ref_mem [8];
  int         last_strobe = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Called with the inputs driven during cycle n. A request registered at
  // edge n+1 is strobed in cycle n+1 if the bridge is idle, acked in n+2.
  task automatic model_step(input int n, input logic rst, input logic stb, input logic cyc,
                            input logic we, input logic [2:0] adr, input logic [7:0] dat);
    strobe_t s;
    ack_t    a;
    if (rst) begin
      last_strobe = -100;
      if (aq.size() > 0 && aq[$].cyc == n + 1) void'(aq.pop_back());
    end else if (stb && cyc && (n + 1 >= last_strobe + 4)) begin
      s.cyc = n + 1; s.we = we; s.adr = adr; s.dat = dat;
      a.cyc = n + 2; a.we = we; a.rdata = we ? 8'd0 : ref_mem[adr];
      sq.push_back(s);
      aq.push_back(a);
      if (we) ref_mem[adr] = dat;
      last_strobe = n + 1;
    end
  endtask

  task automatic step(input logic rst, input logic stb, input logic cyc, input logic we,
                      input logic [2:0] adr, input logic [7:0] dat);
    @(posedge clk);
    #1;
    wb_rst_i   = rst;
    wb_stb_i   = stb;
    wb_cyc_i   = cyc;
    wb_we_i    = we;
    wb_adr_i   = adr;
    wb_dat_i   = dat;
    wb_sel_i   = 4'($urandom);
    wb_dat32_o = $urandom;
    model_step(cycle, rst, stb, cyc, we, adr, dat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'($urandom), 8'($urandom));
  endtask

  // Classic single access: request held two cycles, dropped in the ack cycle.
  task automatic xfer(input logic we, input logic [2:0] adr, input logic [7:0] dat);
    step(1'b0, 1'b1, 1'b1, we, adr, dat);
    step(1'b0, 1'b1, 1'b1, we, adr, dat);
    idle(3);
  endtask

  // Must be called in the first cycle after a reset edge.
  task automatic check_reset_state(input string tag);
    check({tag, "_ack"},      {31'd0, wb_ack_o}, 32'd0);
    check({tag, "_we"},       {31'd0, we_o},     32'd0);
    check({tag, "_re"},       {31'd0, re_o},     32'd0);
    check({tag, "_adr_int"},  {29'd0, wb_adr_int}, 32'd0);
    check({tag, "_dat8_i"},   {24'd0, wb_dat8_i},  32'd0);
    check({tag, "_dat_o"},    {24'd0, wb_dat_o},   32'd0);
  endtask

  // Monitor: compares strobes and acks against the predicted queues.
  always @(negedge clk) begin
    if (cycle >= 1) begin
      while (sq.size() > 0 && sq[0].cyc < cycle) begin
        n_checks++; n_errs++;
        $display("FAIL strobe_missing: no strobe in cycle %0d, expected one", sq[0].cyc);
        void'(sq.pop_front());
      end
      while (aq.size() > 0 && aq[0].cyc < cycle) begin
        n_checks++; n_errs++;
        $display("FAIL ack_missing: no ack in cycle %0d, expected one", aq[0].cyc);
        void'(aq.pop_front());
      end
      if (we_o === 1'b1 || re_o === 1'b1) begin
        if (sq.size() == 0 || sq[0].cyc != cycle) begin
          n_checks++; n_errs++;
          $display("FAIL strobe_spurious: we_o=%0b re_o=%0b in cycle %0d, expected none", we_o, re_o, cycle);
        end else begin
          es = sq.pop_front();
          check("strobe_we_o",   {31'd0, we_o}, {31'd0, es.we});
          check("strobe_re_o",   {31'd0, re_o}, {31'd0, ~es.we});
          check("strobe_adr_int", {29'd0, wb_adr_int}, {29'd0, es.adr});
          check("strobe_dat8_i", {24'd0, wb_dat8_i}, {24'd0, es.dat});
        end
      end
      if (wb_ack_o === 1'b1) begin
        if (aq.size() == 0 || aq[0].cyc != cycle) begin
          n_checks++; n_errs++;
          $display("FAIL ack_spurious: ack in cycle %0d, expected none", cycle);
        end else begin
          ea = aq.pop_front();
          if (!ea.we) check("ack_read_data", {24'd0, wb_dat_o}, {24'd0, ea.rdata});
          else        check("ack_cycle", cycle, ea.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      stub_mem[i] = 8'($urandom);
      ref_mem[i]  = stub_mem[i];
    end
    stub_mem[5] = 8'h5A;
    ref_mem[5]  = 8'h5A;

    // Power-on reset.
    step(1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 8'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    check_reset_state("por");
    idle(2);

    // Write adr 3 = 0x83, then read adr 5 (0x5A).
    xfer(1'b1, 3'd3, 8'h83);
    xfer(1'b0, 3'd5, 8'h00);

    // Held strobe for 10 cycles: strobes every 4 cycles.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00);
    idle(4);

    // Qualification: stb without cyc, cyc without stb.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom), 3'($urandom), 8'($urandom));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom), 3'($urandom), 8'($urandom));
    idle(2);

    // Reset in the strobe cycle, then an immediate new read.
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 8'hC3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 8'hC3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 8'h00);
    check_reset_state("midrst");
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 8'h00);
    idle(4);

    // Back-to-back: write adr 1 = 0x11, read adr 1 right after the ack.
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 8'h11);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 8'h11);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00);
    idle(4);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
           1'($urandom), 3'($urandom), 8'($urandom));
    end
    idle(8);

    check("strobe_queue_drained", sq.size(), 32'd0);
    check("ack_queue_drained",    aq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
